// File: rtl/if_stage.sv
// if_stage: PC register, instruction-ROM request and IF/ID pipeline register with stall, flush, branch and AdEL handling
module if_stage #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_adel_o
);
  logic              ce_r;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              misaligned;
  logic              unused_stall;
  assign unused_stall = ^stall[5:3];
  assign misaligned = |pc[1:0];
  assign rom_addr_o = pc;
  assign rom_ce_o = ce_r & ~misaligned;
  always_comb begin
    pc_nxt = !ce_r ? RESET_PC :
             flush ? new_pc :
             stall[0] ? pc :
             branch_flag_i ? branch_target_i : pc + ADDR_W'(4);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_r <= 1'b0;
      pc   <= RESET_PC;
    end else begin
      ce_r <= 1'b1;
      pc   <= pc_nxt;
    end
  end
  // A stalled IF feeding a running ID inserts a bubble; a stalled ID keeps its instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_o   <= '0;
      id_inst_o <= '0;
      id_adel_o <= 1'b0;
    end else if (flush || (stall[1] && !stall[2])) begin
      id_pc_o   <= '0;
      id_inst_o <= '0;
      id_adel_o <= 1'b0;
    end else if (!stall[1]) begin
      id_pc_o   <= pc;
      id_inst_o <= rom_ce_o ? rom_inst_i : '0;
      id_adel_o <= ce_r & misaligned;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a bench-side combinational ROM
module tb_if_stage;
  typedef struct packed {
    logic [31:0] addr;
    logic        ce;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        adel;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_adel_o;
  vec_t exp_q[$];
  vec_t obs_q[$];
  int n_vec = 0;
  int n_bad = 0;
  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_adel_o(id_adel_o)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a * 32'd3 + 32'h3C00_0001;
  endfunction
  assign rom_inst_i = rom_word(rom_addr_o);
  function automatic vec_t ev(input logic [31:0] a, input logic c, input logic [31:0] p,
                              input logic [31:0] i, input logic d);
    return '{addr: a, ce: c, ipc: p, inst: i, adel: d};
  endfunction
  function automatic vec_t cur();
    return '{addr: rom_addr_o, ce: rom_ce_o, ipc: id_pc_o, inst: id_inst_o, adel: id_adel_o};
  endfunction
  task automatic tick(input logic [5:0] s, input logic f, input logic [31:0] np,
                      input logic b, input logic [31:0] bt, input vec_t e);
    stall = s; flush = f; new_pc = np; branch_flag_i = b; branch_target_i = bt;
    exp_q.push_back(e);
    @(posedge clk);
    #1 obs_q.push_back(cur());
  endtask
  task automatic test_reset();
    vec_t e, o;
    repeat (2) @(posedge clk);
    #1 exp_q.push_back(ev(0, 0, 0, 0, 0));
    obs_q.push_back(cur());
    rst = 1'b0;
    tick(0, 0, 0, 0, 0, ev(32'h0, 1, 32'h0, 0, 0));
    tick(0, 0, 0, 0, 0, ev(32'h4, 1, 32'h0, rom_word(32'h0), 0));
    tick(0, 0, 0, 0, 0, ev(32'h8, 1, 32'h4, rom_word(32'h4), 0));
    tick(0, 0, 0, 0, 0, ev(32'hC, 1, 32'h8, rom_word(32'h8), 0));
    tick(0, 0, 0, 0, 0, ev(32'h10, 1, 32'hC, rom_word(32'hC), 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset: got addr=%h ce=%b pc=%h inst=%h adel=%b, want addr=%h ce=%b pc=%h inst=%h adel=%b",
                 o.addr, o.ce, o.ipc, o.inst, o.adel, e.addr, e.ce, e.ipc, e.inst, e.adel);
      end
    end
  endtask
  task automatic test_branch();
    vec_t e, o;
    tick(0, 0, 0, 1, 32'h100, ev(32'h100, 1, 32'h10, rom_word(32'h10), 0));
    tick(0, 0, 0, 0, 0, ev(32'h104, 1, 32'h100, rom_word(32'h100), 0));
    tick(0, 0, 0, 0, 0, ev(32'h108, 1, 32'h104, rom_word(32'h104), 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL branch: got addr=%h ce=%b pc=%h inst=%h adel=%b, want addr=%h ce=%b pc=%h inst=%h adel=%b",
                 o.addr, o.ce, o.ipc, o.inst, o.adel, e.addr, e.ce, e.ipc, e.inst, e.adel);
      end
    end
  endtask
  task automatic test_stall();
    vec_t e, o;
    tick(0, 1, 32'h4, 0, 0, ev(32'h4, 1, 0, 0, 0));
    tick(0, 0, 0, 0, 0, ev(32'h8, 1, 32'h4, rom_word(32'h4), 0));
    tick(6'b000111, 0, 0, 1, 32'h500, ev(32'h8, 1, 32'h4, rom_word(32'h4), 0));
    tick(6'b000111, 0, 0, 0, 0, ev(32'h8, 1, 32'h4, rom_word(32'h4), 0));
    tick(6'b000011, 0, 0, 0, 0, ev(32'h8, 1, 0, 0, 0));
    tick(6'b000011, 0, 0, 0, 0, ev(32'h8, 1, 0, 0, 0));
    tick(0, 0, 0, 0, 0, ev(32'hC, 1, 32'h8, rom_word(32'h8), 0));
    tick(0, 0, 0, 0, 0, ev(32'h10, 1, 32'hC, rom_word(32'hC), 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL stall: got addr=%h ce=%b pc=%h inst=%h adel=%b, want addr=%h ce=%b pc=%h inst=%h adel=%b",
                 o.addr, o.ce, o.ipc, o.inst, o.adel, e.addr, e.ce, e.ipc, e.inst, e.adel);
      end
    end
  endtask
  task automatic test_flush();
    vec_t e, o;
    tick(6'b000111, 1, 32'h20, 1, 32'h300, ev(32'h20, 1, 0, 0, 0));
    tick(0, 0, 0, 0, 0, ev(32'h24, 1, 32'h20, rom_word(32'h20), 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL flush: got addr=%h ce=%b pc=%h inst=%h adel=%b, want addr=%h ce=%b pc=%h inst=%h adel=%b",
                 o.addr, o.ce, o.ipc, o.inst, o.adel, e.addr, e.ce, e.ipc, e.inst, e.adel);
      end
    end
  endtask
  task automatic test_misaligned();
    vec_t e, o;
    tick(0, 0, 0, 1, 32'h102, ev(32'h102, 0, 32'h24, rom_word(32'h24), 0));
    tick(0, 0, 0, 0, 0, ev(32'h106, 0, 32'h102, 0, 1));
    tick(0, 1, 32'h180, 0, 0, ev(32'h180, 1, 0, 0, 0));
    tick(0, 0, 0, 0, 0, ev(32'h184, 1, 32'h180, rom_word(32'h180), 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL misaligned: got addr=%h ce=%b pc=%h inst=%h adel=%b, want addr=%h ce=%b pc=%h inst=%h adel=%b",
                 o.addr, o.ce, o.ipc, o.inst, o.adel, e.addr, e.ce, e.ipc, e.inst, e.adel);
      end
    end
  endtask
  task automatic test_wrap_reset();
    vec_t e, o;
    tick(0, 1, 32'hFFFF_FFF8, 0, 0, ev(32'hFFFF_FFF8, 1, 0, 0, 0));
    tick(0, 0, 0, 0, 0, ev(32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, rom_word(32'hFFFF_FFF8), 0));
    tick(0, 0, 0, 0, 0, ev(32'h0, 1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 0));
    tick(0, 0, 0, 0, 0, ev(32'h4, 1, 32'h0, rom_word(32'h0), 0));
    #2 rst = 1'b1;
    #1 exp_q.push_back(ev(0, 0, 0, 0, 0));
    obs_q.push_back(cur());
    tick(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));
    rst = 1'b0;
    tick(0, 0, 0, 0, 0, ev(32'h0, 1, 32'h0, 0, 0));
    tick(0, 0, 0, 0, 0, ev(32'h4, 1, 32'h0, rom_word(32'h0), 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL wrap_reset: got addr=%h ce=%b pc=%h inst=%h adel=%b, want addr=%h ce=%b pc=%h inst=%h adel=%b",
                 o.addr, o.ce, o.ipc, o.inst, o.adel, e.addr, e.ce, e.ipc, e.inst, e.adel);
      end
    end
  endtask
  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_flush();
    test_misaligned();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
